// File: rtl/rv32i_load_store_unit_if.sv
// Word-wide memory bus between the RV32I load/store unit (master) and memory (slave).
interface rv32i_load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// RV32I load/store unit: IDLE/ACCESS/DONE sequencer driving a word bus with byte lanes.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module rv32i_load_store_unit (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        memload_flag,
    input  logic        memstore_flag,
    input  logic [2:0]  func3,
    input  logic [31:0] memory_address,
    input  logic [31:0] to_memory,
    output logic [31:0] from_memory,
    output logic        stall,
    output logic        misalign,
    rv32i_load_store_unit_if.master bus
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e            state_q;
    size_e             size_q;
    logic              uns_q;
    logic [1:0]        lo_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   from_memory_q;

    size_e             size_c;
    logic              uns_c;
    logic              req_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   load_c;

    // funct3 decode; reserved codes fall through to word
    always_comb begin
        size_c = SZ_WORD;
        uns_c  = 1'b0;
        case (func3)
            3'b000: size_c = SZ_BYTE;
            3'b001: size_c = SZ_HALF;
            3'b100: begin size_c = SZ_BYTE; uns_c = 1'b1; end
            3'b101: begin size_c = SZ_HALF; uns_c = 1'b1; end
            default: ;
        endcase
    end

    assign req_c = memload_flag | memstore_flag;

    // Store lane placement; loads always read the full word
    always_comb begin
        be_c    = '1;
        wdata_c = to_memory;
        if (memstore_flag) begin
            case (size_c)
                SZ_BYTE: begin
                    be_c    = BE_W'(4'b0001 << memory_address[1:0]);
                    wdata_c = {4{to_memory[7:0]}};
                end
                SZ_HALF: begin
                    be_c    = memory_address[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{to_memory[15:0]}};
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_c;
    logic misalign_q;

    assign misalign_c = ((size_c == SZ_HALF) && memory_address[0]) ||
                        ((size_c == SZ_WORD) && (memory_address[1:0] != 2'b00));
    assign misalign   = misalign_q;
`else
    assign misalign   = 1'b0;
`endif

    // Lane select and extension of the returned word
    always_comb begin
        case (lo_q)
            2'd0:    byte_c = bus.bus_rdata[7:0];
            2'd1:    byte_c = bus.bus_rdata[15:8];
            2'd2:    byte_c = bus.bus_rdata[23:16];
            default: byte_c = bus.bus_rdata[31:24];
        endcase
        half_c = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
            SZ_HALF: load_c = {{16{~uns_q & half_c[15]}}, half_c};
            default: load_c = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q       <= ST_IDLE;
            size_q        <= SZ_WORD;
            uns_q         <= 1'b0;
            lo_q          <= 2'b00;
            we_q          <= 1'b0;
            be_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            from_memory_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        size_q  <= size_c;
                        uns_q   <= uns_c;
                        lo_q    <= memory_address[1:0];
                        we_q    <= memstore_flag;
                        be_q    <= be_c;
                        addr_q  <= {memory_address[XLEN-1:2], 2'b00};
                        wdata_q <= wdata_c;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign_c) begin
                            state_q    <= ST_DONE;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCESS;
                        end
`else
                        state_q <= ST_ACCESS;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (bus.bus_ready) begin
                        state_q <= ST_DONE;
                        if (!we_q) from_memory_q <= load_c;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_q <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stall is combinational so the core freezes in the request cycle itself
    assign stall = ~sys_reset &
                   ((state_q == ST_ACCESS) | ((state_q == ST_IDLE) & req_c));

    assign from_memory   = from_memory_q;
    assign bus.bus_req   = (state_q == ST_ACCESS);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Bench for rv32i_load_store_unit: directed cases plus random loads/stores against an arithmetic model.
module tb_rv32i_load_store_unit;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        memload_flag, memstore_flag;
    logic [2:0]  func3;
    logic [31:0] memory_address, to_memory, from_memory;
    logic        stall, misalign;

    rv32i_load_store_unit_if bus_if ();

    rv32i_load_store_unit dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .memload_flag   (memload_flag),
        .memstore_flag  (memstore_flag),
        .func3          (func3),
        .memory_address (memory_address),
        .to_memory      (to_memory),
        .from_memory    (from_memory),
        .stall          (stall),
        .misalign       (misalign),
        .bus            (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_fm = '0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // One complete transaction: model computes every expectation from the access rules
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int          sz, off, eoff, stall_cycles, req_cycles;
        bit          trap, done, sgn;
        logic [31:0] e_be, e_wd, val, mask;

        sz   = size_of(f3);
        sgn  = (f3 == 3'b000) || (f3 == 3'b001);
        off  = int'(addr[1:0]);
        trap = TRAP && ((off % sz) != 0);
        eoff = (off / sz) * sz;
        e_be = st ? (((32'd1 << sz) - 32'd1) << eoff) : 32'hF;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        val = rd >> (8 * eoff);
        if (sz < 4) begin
            mask = (32'd1 << (8 * sz)) - 32'd1;
            val  = val & mask;
            if (sgn && val[8*sz-1]) val = val | ~mask;
        end

        @(negedge sys_clk);
        memstore_flag  = st;
        memload_flag   = ~st;
        func3          = f3;
        memory_address = addr;
        to_memory      = wd;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = rd;
        stall_cycles = 0;
        req_cycles   = 0;
        done         = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            #1;
            if (cyc > 0 && !stall) begin
                if (!st && !trap) exp_fm = val;
                check("done_req", 32'(bus_if.bus_req), 32'd0);
                check("done_misalign", 32'(misalign), 32'(trap));
                check("from_memory", from_memory, exp_fm);
                done = 1'b1;
                break;
            end
            if (stall) stall_cycles++;
            if (bus_if.bus_req) begin
                check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
                check("bus_we", 32'(bus_if.bus_we), 32'(st));
                check("bus_be", 32'(bus_if.bus_be), e_be);
                if (st) check("bus_wdata", bus_if.bus_wdata, e_wd);
                if (req_cycles == waits) bus_if.bus_ready = 1'b1;
                req_cycles++;
            end
            @(posedge sys_clk);
            #1;
            memstore_flag    = 1'b0;
            memload_flag     = 1'b0;
            bus_if.bus_ready = 1'b0;
            @(negedge sys_clk);
        end
        check("op_done", 32'(done), 32'd1);
        check("stall_cycles", stall_cycles, trap ? 1 : 2 + waits);
        check("req_cycles", req_cycles, trap ? 0 : waits + 1);
        @(negedge sys_clk);
        #1;
        check("idle_misalign", 32'(misalign), 32'd0);
        check("idle_req", 32'(bus_if.bus_req), 32'd0);
    endtask

    initial begin
        sys_reset = 1'b1;
        memload_flag = 1'b0;
        memstore_flag = 1'b0;
        func3 = 3'b010;
        memory_address = '0;
        to_memory = '0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = '0;
        #3;
        check("rst_from_memory", from_memory, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(bus_if.bus_req), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        @(negedge sys_clk);
        sys_reset = 1'b0;

        // SW 0x104
        run_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
        // LB 0x203, two wait states
        run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 2);
        check("lb_value", from_memory, 32'hFFFFFF80);
        // LHU 0x202
        run_op(1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF1234, 0);
        check("lhu_value", from_memory, 32'h000080FF);
        // SH 0x12 leaves from_memory alone
        run_op(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 1);
        check("sh_keeps_fm", from_memory, 32'h000080FF);
        // LW 0x101
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h13579BDF, 0);

        // Reset mid-ACCESS
        @(negedge sys_clk);
        memload_flag = 1'b1;
        func3 = 3'b010;
        memory_address = 32'h300;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 32'hCAFEF00D;
        @(posedge sys_clk);
        #1;
        memload_flag = 1'b0;
        @(negedge sys_clk);
        #1;
        check("pre_rst_req", 32'(bus_if.bus_req), 32'd1);
        #1;
        sys_reset = 1'b1;
        #1;
        check("async_rst_req", 32'(bus_if.bus_req), 32'd0);
        check("async_rst_stall", 32'(stall), 32'd0);
        check("async_rst_fm", from_memory, 32'd0);
        check("async_rst_misalign", 32'(misalign), 32'd0);
        exp_fm = '0;
        @(negedge sys_clk);
        sys_reset = 1'b0;
        @(negedge sys_clk);
        bus_if.bus_ready = 1'b1;
        @(negedge sys_clk);
        bus_if.bus_ready = 1'b0;
        #1;
        check("late_ready_req", 32'(bus_if.bus_req), 32'd0);
        check("late_ready_stall", 32'(stall), 32'd0);
        check("late_ready_fm", from_memory, 32'd0);

        // Random mix, every funct3 code including reserved ones
        for (int k = 0; k < 40; k++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_load_store_unit.md
RV32I_LOAD_STORE_UNIT -- requirements
Module: rv32i_load_store_unit

Interface
REQ-001 sys_clk  input  1  rising-edge clock shared with the core.
REQ-002 sys_reset  input  1  reset, asynchronous, active-high.
REQ-003 memload_flag  input  1  core requests a load this cycle.
REQ-004 memstore_flag  input  1  core requests a store this cycle.
REQ-005 func3  input  3  instruction funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes treated as W.
REQ-006 memory_address  input  32  byte address from the ALU.
REQ-007 to_memory  input  32  store data (rs2 value).
REQ-008 from_memory  output  32  extended load result to the core writeback mux.
REQ-009 stall  output  1  core must hold PC and register writes while 1.
REQ-010 misalign  output  1  one-cycle misaligned-access pulse (see Configuration).
REQ-011 bus_req, bus_we  output  1 each  bus request and write qualifier.
REQ-012 bus_addr  output  32  word-aligned address {memory_address[31:2],2'b00}.
REQ-013 bus_wdata  output  32  lane-replicated store data.
REQ-014 bus_be  output  4  byte enables, bit n = byte lane n.
REQ-015 bus_ready  input  1  bus completes the access this cycle.
REQ-016 bus_rdata  input  32  read word, valid when bus_ready=1.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; shall be one-hot or binary, the encoding is not observable.
REQ-018 IDLE: if memstore_flag or memload_flag is 1, capture address, to_memory and func3, then go to ACCESS; store shall win when both flags are 1.
REQ-019 stall shall be combinationally 1 in IDLE when either flag is 1, and 1 throughout ACCESS.
REQ-020 stall shall be 0 in DONE.
REQ-021 ACCESS: bus_req=1, with bus_addr, bus_we, bus_be and bus_wdata held stable from captured values until bus_ready=1.
REQ-022 On bus_ready=1 in ACCESS, the FSM shall go to DONE and, for a load, register the extended result into from_memory.
REQ-023 DONE shall go to IDLE unconditionally, and flags present in DONE shall be ignored.
REQ-024 Minimum latency shall be 3 cycles (request, ready, done) with stall high for 2 cycles; each cycle of bus_ready=0 adds one cycle.
REQ-025 Byte store: bus_be=1<<addr[1:0] and bus_wdata = byte replicated four times.
REQ-026 Halfword store: bus_be=0011 when addr[1]=0, else 1100, and bus_wdata = halfword replicated twice.
REQ-027 Word store: bus_be=1111.
REQ-028 Load: bus_we=0 and bus_be=1111.
REQ-029 Load result: lane selected by addr[1:0] (B) or addr[1] (H), then sign-extended for B/H or zero-extended for BU/HU.
REQ-030 from_memory shall hold its value until the next load completes, and stores shall not modify it.
REQ-031 bus_req shall be 0 in IDLE and DONE.

Reset
REQ-032 Reset asserted at any time, including mid-ACCESS, shall force IDLE and set bus_req=0, stall=0, misalign=0 and from_memory=0 immediately, without waiting for a clock edge.
REQ-033 Any outstanding bus transfer shall be abandoned on reset; a bus_ready arriving after reset shall be ignored.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN shall select misaligned-access handling.
REQ-035 With LSU_MISALIGN_TRAP_EN defined, a misaligned access (H/HU with addr[0]=1, or W with addr[1:0]!=0) shall go IDLE->DONE directly with no bus_req.
REQ-036 In that misaligned case, misalign=1 in DONE, from_memory is unchanged, and stall is high for 1 cycle.
REQ-037 Without LSU_MISALIGN_TRAP_EN, misalign shall be tied 0, the offending low address bits shall be ignored (forced alignment), and the access proceeds normally.

Verification
REQ-038 Store word: SW, addr 0x104, data 0xDEADBEEF, bus_ready=1 in the first ACCESS cycle -> bus_addr 0x104, bus_be 1111, bus_we 1, stall high 2 cycles.
REQ-039 Load byte: LB, addr 0x203, bus_rdata 0x80FF1234, ready after 2 wait cycles -> from_memory 0xFFFFFF80, stall high 4 cycles.
REQ-040 Load halfword unsigned: LHU, addr 0x202, bus_rdata 0x80FF1234 -> from_memory 0x000080FF.
REQ-041 Store halfword: SH, addr 0x12, data 0x0000ABCD -> bus_be 1100 and bus_wdata 0xABCDABCD.
REQ-042 Misaligned word: LW, addr 0x101 -> with the macro, no bus_req and misalign pulse 1 cycle; without it, bus_addr 0x100 and misalign stays 0.
REQ-043 Reset mid-transfer: LW issued, sys_reset pulsed during ACCESS with bus_ready=0 -> bus_req and stall drop immediately, the FSM is in IDLE, and a subsequent bus_ready has no effect.
